// File: rtl/cosine_quad.sv
// cosine_quad: pipelined full-wave cos/sin from a folded 65-entry quarter-wave table.
// Define COSINE_INTERP_EN to interpolate linearly between table entries.
module cosine_quad #(
   parameter int FRAC_W = 4,
   localparam int PHASE_W = 8 + FRAC_W
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [PHASE_W-1:0] phase_in,
   input  logic               in_valid,
   output logic               in_ready,
   output logic signed [8:0]  cos_out,
   output logic signed [8:0]  sin_out,
   output logic               out_valid,
   input  logic               out_ready
);
   localparam int RW = 6 + FRAC_W;
   localparam int FW = (FRAC_W > 0) ? FRAC_W : 1;
   localparam int PW = 8 + FW;
   localparam logic [RW:0] Q = {1'b1, {RW{1'b0}}};
   localparam logic [7:0] T [65] = '{
      8'd255, 8'd255, 8'd255, 8'd254, 8'd254, 8'd253, 8'd252, 8'd251,
      8'd250, 8'd249, 8'd247, 8'd246, 8'd244, 8'd242, 8'd240, 8'd238,
      8'd236, 8'd233, 8'd231, 8'd228, 8'd225, 8'd222, 8'd219, 8'd215,
      8'd212, 8'd208, 8'd205, 8'd201, 8'd197, 8'd193, 8'd189, 8'd185,
      8'd180, 8'd176, 8'd171, 8'd167, 8'd162, 8'd157, 8'd152, 8'd147,
      8'd142, 8'd136, 8'd131, 8'd126, 8'd120, 8'd115, 8'd109, 8'd103,
      8'd98,  8'd92,  8'd86,  8'd80,  8'd74,  8'd68,  8'd62,  8'd56,
      8'd50,  8'd44,  8'd37,  8'd31,  8'd25,  8'd19,  8'd13,  8'd6,
      8'd0};
   logic w_en;
   logic [3:0] r_v;
   logic [PHASE_W-1:0] r_ph;
   logic [1:0] w_q;
   logic [RW:0] w_r;
   assign w_en = !r_v[3] || out_ready;
   assign in_ready = w_en && resetn;
   assign out_valid = r_v[3];
   assign w_q = r_ph[PHASE_W-1 -: 2];
   assign w_r = {1'b0, r_ph[RW-1:0]};
   always_ff @(posedge clk)
      if (!resetn) r_v <= '0;
      else if (w_en) r_v <= {r_v[2:0], in_valid};
   always_ff @(posedge clk)
      if (w_en) r_ph <= phase_in;
   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic [RW:0] w_rr;
      logic [6:0] w_i;
      logic [7:0] w_m, r_a1, r_a2;
      logic r_n1, r_n2;
      logic signed [8:0] r_y;
      // sine reads the reflected quadrant relative to cosine
      assign w_rr = (w_q[0] ^ (c == 1)) ? Q - w_r : w_r;
      assign w_i = w_rr[RW -: 7];
      always_ff @(posedge clk)
         if (w_en) begin
            r_a1 <= T[w_i];
            r_n1 <= (c == 0) ? ^w_q : w_q[1];
            r_a2 <= r_a1;
            r_n2 <= r_n1;
         end
`ifdef COSINE_INTERP_EN
      logic [7:0] r_b1;
      logic [FW-1:0] r_f1;
      logic [PW-1:0] r_p2;
      always_ff @(posedge clk)
         if (w_en) begin
            r_b1 <= T[(w_i == 7'd64) ? 7'd64 : w_i + 7'd1];
            r_f1 <= (FRAC_W > 0) ? w_rr[FW-1:0] : '0;
            r_p2 <= PW'(r_a1 - r_b1) * PW'(r_f1);
         end
      assign w_m = r_a2 - 8'(r_p2 >> FRAC_W);
`else
      logic w_unused;
      assign w_unused = ^w_rr[FW-1:0];
      assign w_m = r_a2;
`endif
      always_ff @(posedge clk)
         if (!resetn) r_y <= '0;
         else if (w_en && r_v[2]) r_y <= r_n2 ? -$signed({1'b0, w_m}) : $signed({1'b0, w_m});
   end
   assign cos_out = g_ch[0].r_y;
   assign sin_out = g_ch[1].r_y;
endmodule

// File: doc/cosine_quad.md
# cosine_quad

Full-wave, pipelined sine/cosine generator for the microstepper phase-current path. It accepts a full-circle phase word on a valid/ready handshake and returns signed cosine and sine samples together. It folds all four quadrants onto one fixed 65-entry quarter-wave table and optionally interpolates linearly between table entries for sub-entry phase resolution. It sits between the step/phase accumulator and the per-coil PWM current setpoints.

## Interface
Parameters:
- FRAC_W, default 4: number of fractional phase bits between table entries; allowed range is 0..8.
- PHASE_W, default 8+FRAC_W: width of the phase input, derived and not overridable. Bits are {quadrant[1:0], index[5:0], frac[FRAC_W-1:0]}.

Ports:
- clk, input, 1: the single clock.
- resetn, input, 1: reset, synchronous and active-low.
- phase_in, input, PHASE_W: phase; a full circle is 2^PHASE_W.
- in_valid, input, 1: phase_in is valid.
- in_ready, output, 1: block accepts the phase this cycle.
- cos_out, output, 9: signed two's-complement cosine, range -255..+255.
- sin_out, output, 9: signed two's-complement sine, range -255..+255.
- out_valid, output, 1: cos_out and sin_out are valid.
- out_ready, input, 1: the consumer accepts the output.

## Operation
- Table T[i] = round(255·cos(i·π/128)) for i = 0..63, and T[64] = 0.
  - T[0..2] = 255, T[16] = 236, T[17] = 233, T[32] = 180, T[47] = 103, T[48] = 98, T[63] = 6.
- Quarter magnitude C(r) for r in 0..Q, where Q = 2^(6+FRAC_W):
  - i = r >> FRAC_W, f = r mod 2^FRAC_W.
  - C(r) = T[i] − ((T[i] − T[i+1])·f >> FRAC_W). The shift truncates and the difference is unsigned.
  - When f = 0, the table is read at T[i] only, and i = 64 is legal (r = Q gives 0).
- Fold with q = phase[PHASE_W-1:PHASE_W-2] and r = the low 6+FRAC_W bits:
  - q=0: cos = +C(r), sin = +C(Q−r)
  - q=1: cos = −C(Q−r), sin = +C(r)
  - q=2: cos = −C(r), sin = −C(Q−r)
  - q=3: cos = +C(Q−r), sin = −C(r)
- Negation of 0 yields 0; no −0 encoding exists.
- Pipeline has 3 stages, each with a valid bit:
  - S1: fold and register T[i] and T[i+1] for both channels.
  - S2: form the difference and multiply by f.
  - S3: shift, subtract, apply sign, and register the outputs.
- Global advance: en = !out_valid || out_ready. in_ready = en && resetn.
- Bubbles carry valid=0 and advance while en is high. Stages never reorder, drop or duplicate samples.

## Timing
- Reset (resetn low at a clk edge): all stage valids = 0, out_valid = 0, cos_out = 0, sin_out = 0. in_ready is 0 while resetn is low.
- Latency: a phase accepted at edge N produces out_valid at edge N+3 when no backpressure occurs. Throughput is 1 sample per cycle.
- Stall: while out_valid && !out_ready, every stage holds, and cos_out and sin_out remain stable.
- Simultaneous out_ready and in_valid on a full pipeline: the output retires and the new input enters on the same edge.
- Reset mid-stream: in-flight samples are discarded. After resetn rises, the first accepted sample returns 3 cycles later.
- Phase wraps naturally: 2^PHASE_W−1 is adjacent to 0, with no discontinuity beyond one LSB step.

## Configuration
- COSINE_INTERP_EN defined: linear interpolation as specified above.
- COSINE_INTERP_EN undefined:
  - f is ignored and C(r) = T[r >> FRAC_W], i.e. truncated to the entry.
  - The multiplier is not instantiated.
  - Latency stays at 3 cycles and the handshake is unchanged.

## Test plan
All scenarios use FRAC_W = 4, PHASE_W = 12, Q = 1024.
- Cardinal phases: 0x000, 0x400, 0x800, 0xC00 → (cos, sin) = (255, 0), (0, 255), (−255, 0), (0, −255). out_valid appears exactly 3 cycles after acceptance.
- 45°: phase 0x200 → (180, 180). Phase 0x600 → (−180, 180).
- Interpolation: phase 0x2F8 → cos 101, sin 235 with COSINE_INTERP_EN; cos 103, sin 236 without it.
- Backpressure: stream 8 consecutive phases, hold out_ready low for 5 cycles mid-stream.
  - in_ready drops.
  - Outputs stay stable while stalled.
  - All 8 results emerge in order with no loss or duplication.
- Reset mid-stream: pull resetn low for 1 cycle with 3 samples in flight.
  - Next cycle out_valid = 0 and the outputs are 0.
  - None of the discarded samples ever appears.
- Sweep all 4096 phases against a golden model: exact match, and cos²+sin² stays within ±3% of 255².
